bcd_scan_display: RTL and testbench

BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

---
 rtl/bcd_scan_display_if.sv | 24 ++
 rtl/bcd_scan_display.sv | 133 +++++++++++++
 tb/tb_bcd_scan_display.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_display_if.sv
// Bus bundle for bcd_scan_display: value load/increment controls in,
// multiplexed seven-segment drive and overflow pulse out.
interface bcd_scan_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic                      inc;
  logic [4*NUM_DIGITS-1:0]   bcd_in;
  logic [6:0]                seg;
  logic [NUM_DIGITS-1:0]     dig_en;
  logic                      ovf;

  // Controller side: drives the value controls, observes the display.
  modport master (
    output load, inc, bcd_in,
    input  seg, dig_en, ovf
  );

  // Display side: the bcd_scan_display block itself.
  modport slave (
    input  load, inc, bcd_in,
    output seg, dig_en, ovf
  );
endinterface

// File: rtl/bcd_scan_display.sv
// Multi-digit BCD register with decimal increment and a time-multiplexed
// seven-segment scanner. Each digit is shown for SCAN_DIV cycles in turn.
// Optional build macro BCD_SCAN_LEADING_ZERO_BLANK_EN blanks leading zero
// digits (never digit 0); without it every digit is decoded.
module bcd_scan_display #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_scan_display_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0][3:0] r_value;
  logic [CNT_W-1:0]           r_cnt;
  logic [IDX_W-1:0]           r_idx;
  logic [6:0]                 r_seg;
  logic [NUM_DIGITS-1:0]      r_dig_en;
  logic                       r_ovf;

  logic [NUM_DIGITS-1:0][3:0] w_value_inc;
  logic                       w_carry_out;
  logic [3:0]                 w_nib;
  logic [6:0]                 w_seg_dec;
  logic                       w_blank;

  // Decimal increment with ripple carry; invalid nibbles roll to 0 and carry.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_value_inc = r_value;
    w_carry_out = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_carry_out) begin
        if (r_value[k] >= 4'd9) begin
          w_value_inc[k] = 4'd0;
        end else begin
          w_value_inc[k] = r_value[k] + 4'd1;
          w_carry_out    = 1'b0;
        end
      end
    end
  end

  assign w_nib = r_value[r_idx];

  // Seven-segment decode {a,b,c,d,e,f,g}; non-decimal nibbles show a dash.
  always_comb begin
    unique case (w_nib)
      4'd0:    w_seg_dec = 7'b1111110;
      4'd1:    w_seg_dec = 7'b0110000;
      4'd2:    w_seg_dec = 7'b1101101;
      4'd3:    w_seg_dec = 7'b1111001;
      4'd4:    w_seg_dec = 7'b0110011;
      4'd5:    w_seg_dec = 7'b1011011;
      4'd6:    w_seg_dec = 7'b1011111;
      4'd7:    w_seg_dec = 7'b1110000;
      4'd8:    w_seg_dec = 7'b1111111;
      4'd9:    w_seg_dec = 7'b1111011;
      default: w_seg_dec = 7'b0000001;
    endcase
  end

`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
  logic w_upper_zero;

  // Blank the current digit if it and every digit above it are zero.
  // Walking down from the top keeps a running "all zero so far" flag.
  always_comb begin
    w_blank      = 1'b0;
    w_upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_upper_zero = w_upper_zero & (r_value[k] == 4'd0);
      if (IDX_W'(k) == r_idx) w_blank = w_upper_zero;
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  // Value register: load has priority over increment; ovf marks a wrap.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_value <= '0;
      r_ovf   <= 1'b0;
    end else if (bus.load) begin
      r_value <= bus.bcd_in;
      r_ovf   <= 1'b0;
    end else if (bus.inc) begin
      r_value <= w_value_inc;
      r_ovf   <= w_carry_out;
    end else begin
      r_ovf   <= 1'b0;
    end
  end

  // Scan timing: prescaler wraps at SCAN_DIV-1 and advances the digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Registered display drive, one cycle behind the index and value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg    <= '0;
      r_dig_en <= '0;
    end else begin
      r_seg    <= w_blank ? 7'b0000000 : w_seg_dec;
      r_dig_en <= NUM_DIGITS'(1) << r_idx;
    end
  end

  assign bus.seg    = r_seg;
  assign bus.dig_en = r_dig_en;
  assign bus.ovf    = r_ovf;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display (NUM_DIGITS=4, SCAN_DIV=4).
// A reference model tracks the stored value as a plain number and derives
// the displayed digit from the count of cycles since reset.
module tb_bcd_scan_display;

  localparam int ND = 4;
  localparam int SD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bcd_scan_display_if #(.NUM_DIGITS(ND)) bus ();

  bcd_scan_display #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [4*ND-1:0] m_val;
  int              m_cyc;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000001;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge: predict outputs from the model, advance model, compare.
  task automatic tick();
    logic [6:0]      e_seg;
    logic [ND-1:0]   e_dig;
    logic            e_ovf;
    logic [4*ND-1:0] n_val;
    logic [3:0]      nib;
    logic            carry;
    int              idx;

    e_seg = '0;
    e_dig = '0;
    e_ovf = 1'b0;
    n_val = m_val;
    if (!rst_n) begin
      n_val = '0;
    end else begin
      idx   = (m_cyc / SD) % ND;
      nib   = m_val[4*idx +: 4];
      e_seg = seg_of(nib);
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
      if (idx > 0 && (m_val >> (4*idx)) == 0) e_seg = 7'b0000000;
`endif
      e_dig = ND'(1) << idx;
      if (bus.load) begin
        n_val = bus.bcd_in;
      end else if (bus.inc) begin
        carry = 1'b1;
        for (int k = 0; k < ND; k++) begin
          nib = m_val[4*k +: 4];
          if (carry) begin
            if (nib >= 4'd9) nib = 4'd0;
            else begin nib = nib + 4'd1; carry = 1'b0; end
          end
          n_val[4*k +: 4] = nib;
        end
        e_ovf = carry;
      end
    end

    @(posedge clk);
    #1;
    if (!rst_n) m_cyc = 0;
    else        m_cyc++;
    m_val = n_val;

    check("seg",    32'(bus.seg),    32'(e_seg));
    check("dig_en", 32'(bus.dig_en), 32'(e_dig));
    check("ovf",    32'(bus.ovf),    32'(e_ovf));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_val(input logic [4*ND-1:0] v, input logic with_inc);
    bus.load   = 1'b1;
    bus.inc    = with_inc;
    bus.bcd_in = v;
    tick();
    bus.load   = 1'b0;
    bus.inc    = 1'b0;
  endtask

  initial begin
    m_val      = '0;
    m_cyc      = 0;
    bus.load   = 1'b1;
    bus.inc    = 1'b1;
    bus.bcd_in = 16'hFFFF;

    // Reset wins over load/inc.
    rst_n = 1'b0;
    tick();
    check("rst_seg",    32'(bus.seg),    32'h0);
    check("rst_dig_en", 32'(bus.dig_en), 32'h0);
    check("rst_ovf",    32'(bus.ovf),    32'h0);
    tick();

    // Release with idle controls: scan of an all-zero value.
    bus.load = 1'b0;
    bus.inc  = 1'b0;
    rst_n    = 1'b1;
    tick();
    check("first_seg",    32'(bus.seg),    32'b1111110);
    check("first_dig_en", 32'(bus.dig_en), 32'b0001);
    ticks(16);

    // Per-digit decode.
    load_val(16'h1234, 1'b0);
    ticks(17);

    // Increment with carry, then full wrap with ovf.
    load_val(16'h0199, 1'b0);
    bus.inc = 1'b1; tick(); bus.inc = 1'b0;
    ticks(16);
    load_val(16'h9999, 1'b0);
    bus.inc = 1'b1; tick(); bus.inc = 1'b0;
    check("wrap_ovf_hi", 32'(bus.ovf), 32'h1);
    tick();
    check("wrap_ovf_lo", 32'(bus.ovf), 32'h0);
    ticks(16);

    // Load and inc together: load wins, invalid nibble shows a dash.
    load_val(16'h00A5, 1'b1);
    ticks(16);

    // Leading zeros.
    load_val(16'h0007, 1'b0);
    ticks(16);

    // Invalid nibbles under increment.
    load_val(16'h9F9C, 1'b0);
    bus.inc = 1'b1; tick(); bus.inc = 1'b0;
    ticks(16);

    // Reset mid-scan, and reset during an all-9s increment.
    load_val(16'h5555, 1'b0);
    ticks(6);
    rst_n = 1'b0; tick();
    rst_n = 1'b1; ticks(8);
    load_val(16'h9999, 1'b0);
    bus.inc = 1'b1; rst_n = 1'b0; tick();
    bus.inc = 1'b0; rst_n = 1'b1; ticks(8);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bus.load   = ($urandom_range(0, 7) == 0);
      bus.inc    = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0:       bus.bcd_in = 16'h9999;
        1:       bus.bcd_in = 16'($urandom);
        2:       bus.bcd_in = 16'($urandom_range(0, 15));
        default: bus.bcd_in = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                               4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      endcase
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end
    bus.load = 1'b0;
    bus.inc  = 1'b0;
    rst_n    = 1'b1;
    ticks(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
